// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   fetch_state_e : fetch request FSM states (IDLE, WAIT, DROP)
//   NOP_INST      : encoding of a bubble on the decode interface
//   clog2()       : ceiling log2, used to size counters and pointers
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request on the bus, waiting for IAck
    DROP = 2'd2   // request squashed by a branch, waiting for its stale IAck
  } fetch_state_e;

  localparam int unsigned NOP_INST = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus bundle of the fetch stage: the IRAM request/return side and the
// decode side.
//   master : the fetch stage (drives IRead/IAddr/Fetched/FetchedPC/Flush)
//   slave  : the environment (IRAM + decode + branch unit)
interface ifetch_queue_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [DW-1:0] Inst;
  logic          IAck;
  logic          IRead;
  logic [AW-1:0] IAddr;
  logic          Stall;
  logic          BranchTaken;
  logic [AW-1:0] BranchTarget;
  logic [DW-1:0] Fetched;
  logic [AW-1:0] FetchedPC;
  logic          Flush;

  modport master (
    input  Inst, IAck, Stall, BranchTaken, BranchTarget,
    output IRead, IAddr, Fetched, FetchedPC, Flush
  );

  modport slave (
    output Inst, IAck, Stall, BranchTaken, BranchTarget,
    input  IRead, IAddr, Fetched, FetchedPC, Flush
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO holding prefetched {instruction, PC} entries.
//   Clk, Reset      : clock, synchronous active-high reset
//   push_i, data_i  : write an entry (ignored when full)
//   pop_i           : drop the head entry (ignored when empty)
//   clear_i         : empty the FIFO; wins over push
//   data_o          : current head entry (valid when !empty_o)
//   count_o, full_o, empty_o : occupancy
// Same-cycle push and pop is legal and leaves the count unchanged.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter  int unsigned W     = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned PW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read behind a valid count,
  // so resetting the array would cost flops and buy nothing.
  always_ff @(posedge Clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage with a prefetch queue.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : ifetch_queue_if.master
//                IRAM side  : IRead/IAddr out, Inst/IAck in (one request max)
//                decode side: Fetched/FetchedPC out (0/0 = bubble), Stall in
//                redirect   : BranchTaken/BranchTarget in
//                Flush out  : high for FLUSH_CYCLES edges after Reset falls
// Words land in the queue one edge before they can reach Fetched; there is
// no bypass from Inst to Fetched.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned   DW           = 32,
  parameter int unsigned   AW           = 32,
  parameter int unsigned   DEPTH        = 4,
  parameter int unsigned   FLUSH_CYCLES = 6,
  parameter logic [AW-1:0] RESET_PC     = '0,
  parameter int unsigned   INST_BYTES   = 4
) (
  input logic            Clk,
  input logic            Reset,
  ifetch_queue_if.master bus
);
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam int unsigned FW = clog2(FLUSH_CYCLES + 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          flush_q;
  logic [FW-1:0] flush_cnt_q;
  logic [DW-1:0] fetched_q;
  logic [AW-1:0] fetched_pc_q;

  logic [DW+AW-1:0] head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             branch, push, pop;

  // A branch is ignored while the pipeline is still settling after reset.
  assign branch = !flush_q && bus.BranchTaken;
  assign push   = (state_q == WAIT) && bus.IAck && !branch;
  assign pop    = !flush_q && !branch && !bus.Stall && !fifo_empty;

  ifetch_queue_fifo #(.W(DW + AW), .DEPTH(DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (branch),
    .data_i  ({bus.Inst, pc_q}),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no
    // latch can be inferred.
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: if (!flush_q && !bus.BranchTaken && !fifo_full) state_d = WAIT;
      WAIT: begin
        if (branch) begin
          state_d = bus.IAck ? IDLE : DROP;
        end else if (bus.IAck && (fifo_count == CW'(DEPTH - 1)) && !pop) begin
          // This push fills the queue: stop requesting until it drains.
          state_d = IDLE;
        end
      end
      DROP:    if (bus.IAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (branch)    pc_d = bus.BranchTarget;
    else if (push) pc_d = pc_q + AW'(INST_BYTES);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      flush_q      <= 1'b1;
      flush_cnt_q  <= '0;
      fetched_q    <= DW'(NOP_INST);
      fetched_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (flush_q) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) flush_q <= 1'b0;
      end
      // Flush > BranchTaken > Stall; a branch bubbles even when stalled.
      if (flush_q || branch) begin
        fetched_q    <= DW'(NOP_INST);
        fetched_pc_q <= '0;
      end else if (!bus.Stall) begin
        if (!fifo_empty) begin
          fetched_q    <= head[AW +: DW];
          fetched_pc_q <= head[AW-1:0];
        end else begin
          fetched_q    <= DW'(NOP_INST);
          fetched_pc_q <= '0;
        end
      end
    end
  end

  assign bus.IRead     = (state_q == WAIT);
  assign bus.IAddr     = pc_q;
  assign bus.Fetched   = fetched_q;
  assign bus.FetchedPC = fetched_pc_q;
  assign bus.Flush     = flush_q;

endmodule
